puf_measure_ctrl: RTL and testbench
===================================

Name: puf_measure_ctrl

Overview:
Clocked measurement controller that consumes the raw ring-oscillator outputs of two PUF oscillator banks and turns them into a response word.
- For each of NUM_BITS challenge indices it drives the bank select, waits for the muxes to settle, and counts synchronized rising edges of both oscillators over a fixed clk window.
- It compares the two counts and shifts the result into the response register.
- It replaces the free-running asynchronous counters and comparator with a deterministic, clk-timed stage feeding uo_out.

Parameters:
- WINDOW_CYCLES, 256: clk cycles per counting window.
- SETTLE_CYCLES, 4: clk cycles after each sel change before counting starts, for mux and synchronizer settling.
- CNT_W, 12: edge counter width; counters saturate at all-ones.
- NUM_BITS, 8: response bits per run; sel width is clog2(NUM_BITS).

Ports:
- clk, input, 1: system clock.
- rst_n, input, 1: reset, asynchronous and active-low.
- start, input, 1: one-cycle pulse that starts a run; ignored while busy.
- ro_a, input, 1: raw oscillator output, bank A mux; asynchronous to clk.
- ro_b, input, 1: raw oscillator output, bank B mux; asynchronous to clk.
- sel, output, clog2(NUM_BITS): challenge index driven to both bank muxes.
- busy, output, 1: high from the cycle after accepted start until done.
- done, output, 1: one-cycle pulse when the response is complete.
- response, output, NUM_BITS: response word; bit i comes from sel=i.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - FSM goes to IDLE.
  - sel, busy, done, response, both counters, the window/settle timer and the synchronizers all clear to 0.
- Input synchronization:
  - ro_a and ro_b each pass through a 2-flop synchronizer plus an edge-detect flop.
  - A count event is a synchronized 0->1 transition.
  - Accurate counting requires an oscillator frequency below clk/2; faster inputs alias, and this is accepted behaviour.
- FSM states: IDLE, SETTLE, MEASURE, COMPARE, FINISH.
- IDLE:
  - On start, clear response, set sel=0, set busy=1 and go to SETTLE.
- SETTLE:
  - Counters are held at 0 and edges are discarded.
  - After SETTLE_CYCLES cycles, go to MEASURE.
- MEASURE:
  - Both counters increment on their own edge events; each counter saturates at 2^CNT_W-1 and never wraps.
  - The window is exactly WINDOW_CYCLES cycles, after which the FSM goes to COMPARE.
- COMPARE (one cycle):
  - bit = (cnt_a > cnt_b), as an unsigned full-width compare. A tie gives 0.
  - The bit is written to response[sel].
  - If sel == NUM_BITS-1, go to FINISH. Otherwise increment sel, clear the counters and go to SETTLE.
- FINISH (one cycle):
  - Pulse done=1, drop busy to 0 and return to IDLE.
  - sel holds its last value and response holds until the next accepted start.
- Latency: start accepted at cycle 0; done asserts at cycle NUM_BITS*(SETTLE_CYCLES+WINDOW_CYCLES+1)+1.
- Boundary cases:
  - start while busy is ignored with no restart.
  - start coincident with FINISH is ignored.
  - rst_n low mid-run aborts immediately: all outputs return to 0 and no done is produced.
  - Edge events arriving in the same cycle on both inputs are both counted.

Optional Feature:
- Macro PUF_TIE_FLAG_EN.
- When defined: adds output tie_mask[NUM_BITS-1:0], cleared at start and reset. Bit i is set in COMPARE when cnt_a == cnt_b, including when both counters are saturated. This flags unreliable response bits for helper-data processing.
- When undefined: the port and its logic are absent; ties silently produce 0.

Decomposition:
- Shared package puf_pkg holds:
  - enum puf_state_t {IDLE, SETTLE, MEASURE, COMPARE, FINISH};
  - default constants PUF_WINDOW_CYCLES, PUF_SETTLE_CYCLES, PUF_CNT_W.
- One natural sub-module, puf_edge_counter, instantiated twice. It contains the synchronizer, edge detect and saturating counter, with inputs clk, rst_n, clr, en, ro and output cnt.

Test Plan:
- Reset value check: assert rst_n=0 with random ro toggling -> sel=0, busy=0, done=0, response=0. Release with no start -> all outputs stay 0.
- Frequency discrimination: WINDOW_CYCLES=60, ro_a period 6 clk, ro_b period 10 clk, for all challenges -> response=8'hFF. Internal cnt_a must be 9-11 and cnt_b 5-7 per window. done arrives at cycle 8*(4+60+1)+1=521.
- Per-challenge mapping: a bench model makes ro_a faster only when sel is odd -> response=8'hAA, and sel steps 0..7 in order.
- Saturation and tie: CNT_W=4, both ro at period 4 over WINDOW_CYCLES=256 -> both counters stick at 15 and response=8'h00. With PUF_TIE_FLAG_EN, tie_mask=8'hFF.
- Start during busy: second start pulse at cycle 100 -> no restart, and done still arrives at the nominal cycle.
- Reset mid-run: rst_n low during MEASURE of bit 3 -> outputs return to 0 and no done. A new start then gives a full, correct run.

Source files
------------

// File: rtl/puf_pkg.sv
// Shared definitions for the PUF measurement controller.
// Holds the FSM state type and the default timing/width constants
// used by puf_measure_ctrl and puf_edge_counter.
package puf_pkg;

  // Measurement sequencer states
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETTLE  = 3'd1,
    MEASURE = 3'd2,
    COMPARE = 3'd3,
    FINISH  = 3'd4
  } puf_state_t;

  // Default clk cycles per counting window
  localparam int PUF_WINDOW_CYCLES = 256;
  // Default clk cycles of mux/synchronizer settling after each sel change
  localparam int PUF_SETTLE_CYCLES = 4;
  // Default edge counter width
  localparam int PUF_CNT_W         = 12;
  // Default number of response bits per run
  localparam int PUF_NUM_BITS      = 8;

  // Width of a timer that must reach max(window, settle) - 1
  function automatic int puf_timer_w(input int window_cycles, input int settle_cycles);
    int longest;
    longest = (window_cycles > settle_cycles) ? window_cycles : settle_cycles;
    return (longest > 1) ? $clog2(longest) : 1;
  endfunction

  // Width of the challenge index for a given number of response bits
  function automatic int puf_sel_w(input int num_bits);
    return (num_bits > 1) ? $clog2(num_bits) : 1;
  endfunction

endpackage

// File: rtl/puf_edge_counter.sv
// Synchronizes one raw ring-oscillator output into the clk domain,
// detects synchronized rising edges and counts them with saturation.
// clr has priority over en; the counter sticks at all-ones instead of
// wrapping so a very fast oscillator never looks slow.
module puf_edge_counter
  import puf_pkg::*;
#(
  parameter int CNT_W = PUF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic             ro,
  output logic [CNT_W-1:0] cnt
);

  logic sync_meta;
  logic sync_q;
  logic prev_q;
  logic rise_evt;

  // Two-flop synchronizer for the asynchronous oscillator plus edge-detect history
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_meta <= 1'b0;
      sync_q    <= 1'b0;
      prev_q    <= 1'b0;
    end else begin
      sync_meta <= ro;
      sync_q    <= sync_meta;
      prev_q    <= sync_q;
    end
  end

  assign rise_evt = sync_q & ~prev_q;

  // Saturating count of synchronized 0->1 transitions while enabled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && rise_evt && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/puf_measure_ctrl.sv
// Clocked PUF measurement controller. For each challenge index it drives
// sel to both oscillator bank muxes, waits SETTLE_CYCLES, counts edges of
// both oscillators for WINDOW_CYCLES, then compares the counts and stores
// (cnt_a > cnt_b) into response[sel].
// Optional feature macro: PUF_TIE_FLAG_EN adds tie_mask, which flags
// response bits whose two counts were equal.
module puf_measure_ctrl
  import puf_pkg::*;
#(
  parameter int WINDOW_CYCLES = PUF_WINDOW_CYCLES,
  parameter int SETTLE_CYCLES = PUF_SETTLE_CYCLES,
  parameter int CNT_W         = PUF_CNT_W,
  parameter int NUM_BITS      = PUF_NUM_BITS,
  parameter int SEL_W         = puf_sel_w(NUM_BITS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                ro_a,
  input  logic                ro_b,
  output logic [SEL_W-1:0]    sel,
  output logic                busy,
  output logic                done,
  output logic [NUM_BITS-1:0] response
`ifdef PUF_TIE_FLAG_EN
  ,
  output logic [NUM_BITS-1:0] tie_mask
`endif
);

  localparam int TMR_W = puf_timer_w(WINDOW_CYCLES, SETTLE_CYCLES);
  localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYCLES - 1);
  localparam logic [TMR_W-1:0] WINDOW_LAST = TMR_W'(WINDOW_CYCLES - 1);
  localparam logic [SEL_W-1:0] SEL_LAST    = SEL_W'(NUM_BITS - 1);

  puf_state_t       state;
  puf_state_t       state_next;
  logic [TMR_W-1:0] timer;
  logic [CNT_W-1:0] cnt_a;
  logic [CNT_W-1:0] cnt_b;
  logic             cnt_clr;
  logic             cnt_en;
  logic             run_start;
  logic             bit_val;
  logic             bit_tie;

  // Counters only run inside the window; everywhere else they are held at zero,
  // which also discards edges seen while the muxes settle.
  assign cnt_en  = (state == MEASURE);
  assign cnt_clr = (state != MEASURE);

  assign run_start = (state == IDLE) && start;
  assign bit_val   = (cnt_a > cnt_b);
  assign bit_tie   = (cnt_a == cnt_b);

  puf_edge_counter #(
    .CNT_W (CNT_W)
  ) u_cnt_a (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .ro    (ro_a),
    .cnt   (cnt_a)
  );

  puf_edge_counter #(
    .CNT_W (CNT_W)
  ) u_cnt_b (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .ro    (ro_b),
    .cnt   (cnt_b)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode; start is only honoured in IDLE, so it is ignored
  // while busy and during FINISH.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_next = SETTLE;
        end
      end
      SETTLE: begin
        if (timer == SETTLE_LAST) begin
          state_next = MEASURE;
        end
      end
      MEASURE: begin
        if (timer == WINDOW_LAST) begin
          state_next = COMPARE;
        end
      end
      COMPARE: begin
        if (sel == SEL_LAST) begin
          state_next = FINISH;
        end else begin
          state_next = SETTLE;
        end
      end
      FINISH: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Shared settle/window timer, restarted on every state change
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer <= '0;
    end else if (state_next != state) begin
      timer <= '0;
    end else if ((state == SETTLE) || (state == MEASURE)) begin
      timer <= timer + TMR_W'(1);
    end
  end

  // Challenge index: reset at run start, stepped after each compare except the last
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel <= '0;
    end else if (run_start) begin
      sel <= '0;
    end else if ((state == COMPARE) && (sel != SEL_LAST)) begin
      sel <= sel + SEL_W'(1);
    end
  end

  // Response word: cleared at run start, one bit written per compare
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      response <= '0;
    end else if (run_start) begin
      response <= '0;
    end else if (state == COMPARE) begin
      response[sel] <= bit_val;
    end
  end

  // Registered status: busy covers the whole measurement, done marks FINISH
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= (state_next == SETTLE) || (state_next == MEASURE) || (state_next == COMPARE);
      done <= (state_next == FINISH);
    end
  end

`ifdef PUF_TIE_FLAG_EN
  // Tie flags for helper-data processing; saturated-equal counts count as ties
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tie_mask <= '0;
    end else if (run_start) begin
      tie_mask <= '0;
    end else if (state == COMPARE) begin
      tie_mask[sel] <= bit_tie;
    end
  end
`else
  logic unused_tie;
  assign unused_tie = bit_tie;
`endif

endmodule

// File: tb/tb_puf_measure_ctrl.sv
// Self-checking bench for puf_measure_ctrl (small window, 4-bit counters).
// Oscillators are modelled as clk-synchronous square waves whose periods
// depend on the sel the DUT drives; each challenge is given a mode:
//   0 = A clearly faster, 1 = B clearly faster,
//   2 = identical waveforms (exact tie), 3 = both far above saturation (tie).
// Expected response bit is 1 only for mode 0.
module tb_puf_measure_ctrl;

  localparam int NB  = 8;
  localparam int WIN = 60;
  localparam int SET = 4;
  localparam int CW  = 4;
  localparam int LAT = NB * (SET + WIN + 1) + 1;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          ro_a;
  logic          ro_b;
  logic [2:0]    sel;
  logic          busy;
  logic          done;
  logic [NB-1:0] response;
`ifdef PUF_TIE_FLAG_EN
  logic [NB-1:0] tie_mask;
`endif

  int checks;
  int errors;

  int pa [NB];
  int pb [NB];
  bit tie_b [NB];
  int pha;
  int phb;

  typedef struct {
    string      name;
    logic [15:0] modes;
    logic [7:0]  exp_resp;
    bit          inject_busy;
  } vec_t;

  vec_t vecs [5];

  puf_measure_ctrl #(
    .WINDOW_CYCLES (WIN),
    .SETTLE_CYCLES (SET),
    .CNT_W         (CW),
    .NUM_BITS      (NB)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .ro_a     (ro_a),
    .ro_b     (ro_b),
    .sel      (sel),
    .busy     (busy),
    .done     (done),
    .response (response)
`ifdef PUF_TIE_FLAG_EN
    ,
    .tie_mask (tie_mask)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Oscillator models, updated away from the sampling edge
  always @(negedge clk) begin
    int s;
    s = int'(sel);
    pha = (pha + 1) % pa[s];
    phb = (phb + 1) % pb[s];
    ro_a = (pha < pa[s] / 2);
    ro_b = tie_b[s] ? ro_a : (phb < pb[s] / 2);
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  function automatic logic [NB-1:0] modelResponse(input logic [15:0] m);
    logic [NB-1:0] r;
    for (int i = 0; i < NB; i++) r[i] = (m[2*i +: 2] == 2'd0);
    return r;
  endfunction

  function automatic logic [NB-1:0] modelTie(input logic [15:0] m);
    logic [NB-1:0] r;
    for (int i = 0; i < NB; i++) r[i] = (m[2*i +: 2] >= 2'd2);
    return r;
  endfunction

  // Load per-challenge oscillator periods for the given modes
  task automatic configure(input logic [15:0] m, input bit rnd);
    for (int i = 0; i < NB; i++) begin
      int fast;
      int slow;
      fast = rnd ? int'($urandom_range(6, 4)) : 6;
      slow = rnd ? 8 + 2 * int'($urandom_range(2, 0)) : 10;
      tie_b[i] = 1'b0;
      case (m[2*i +: 2])
        2'd0: begin pa[i] = fast; pb[i] = slow; end
        2'd1: begin pa[i] = slow; pb[i] = fast; end
        2'd2: begin pa[i] = int'($urandom_range(12, 2)); pb[i] = pa[i]; tie_b[i] = 1'b1; end
        default: begin pa[i] = 2; pb[i] = 3; end
      endcase
    end
  endtask

  // Full run: start, track sel order and latency, check result and FINISH behaviour
  task automatic applyStimulus(input string name, input logic [15:0] m, input logic [7:0] exp_resp,
                               input bit inject_busy, input bit rnd);
    int cyc;
    int selq[$];
    bit order_ok;
    configure(m, rnd);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    checkOutput({name, "_busy_rise"}, {31'd0, busy}, 32'd1);
    selq.delete();
    selq.push_back(int'(sel));
    while (done !== 1'b1 && cyc < LAT + 40) begin
      @(negedge clk);
      cyc++;
      start = inject_busy && (cyc == 100);
      if (int'(sel) != selq[$]) selq.push_back(int'(sel));
    end
    start = 1'b0;
    checkOutput({name, "_latency"}, cyc, LAT);
    checkOutput({name, "_response"}, {24'd0, response}, {24'd0, exp_resp});
    checkOutput({name, "_busy_at_done"}, {31'd0, busy}, 32'd0);
`ifdef PUF_TIE_FLAG_EN
    checkOutput({name, "_tie_mask"}, {24'd0, tie_mask}, {24'd0, modelTie(m)});
`endif
    order_ok = (selq.size() == NB);
    for (int i = 0; i < selq.size() && i < NB; i++) if (selq[i] != i) order_ok = 1'b0;
    checkOutput({name, "_sel_order"}, {31'd0, order_ok}, 32'd1);
    // start coincident with FINISH must be ignored
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput({name, "_done_pulse"}, {31'd0, done}, 32'd0);
    checkOutput({name, "_finish_start_ignored"}, {31'd0, busy}, 32'd0);
    checkOutput({name, "_sel_hold"}, {29'd0, sel}, NB - 1);
    checkOutput({name, "_resp_hold"}, {24'd0, response}, {24'd0, exp_resp});
    repeat (3) @(negedge clk);
  endtask

  task automatic checkAllZero(input string name);
    checkOutput({name, "_sel"}, {29'd0, sel}, 32'd0);
    checkOutput({name, "_busy"}, {31'd0, busy}, 32'd0);
    checkOutput({name, "_done"}, {31'd0, done}, 32'd0);
    checkOutput({name, "_response"}, {24'd0, response}, 32'd0);
  endtask

  initial begin
    int dcount;
    logic [15:0] m;
    checks = 0;
    errors = 0;
    pha = 0;
    phb = 0;
    start = 1'b0;
    rst_n = 1'b0;
    ro_a = 1'b0;
    ro_b = 1'b0;
    for (int i = 0; i < NB; i++) begin
      pa[i] = int'($urandom_range(9, 2));
      pb[i] = int'($urandom_range(9, 2));
      tie_b[i] = 1'b0;
    end

    vecs[0] = '{"all_a_fast", 16'h0000, 8'hFF, 1'b0};
    vecs[1] = '{"odd_a_fast", 16'h1111, 8'hAA, 1'b0};
    vecs[2] = '{"saturated",  16'hFFFF, 8'h00, 1'b0};
    vecs[3] = '{"identical",  16'hAAAA, 8'h00, 1'b0};
    vecs[4] = '{"mixed_busy", 16'h709C, 8'h31, 1'b1};

    // Reset with oscillators toggling
    repeat (5) @(negedge clk);
    checkAllZero("reset");
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    checkAllZero("post_reset_idle");

    // Table-driven runs
    for (int v = 0; v < 5; v++) begin
      applyStimulus(vecs[v].name, vecs[v].modes, vecs[v].exp_resp, vecs[v].inject_busy, 1'b0);
    end

    // Abort during MEASURE of bit 3
    configure(16'h0000, 1'b0);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (229) @(negedge clk);
    checkOutput("abort_sel_before", {29'd0, sel}, 32'd3);
    rst_n = 1'b0;
    #1;
    checkAllZero("abort");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    dcount = 0;
    for (int c = 0; c < LAT + 20; c++) begin
      @(negedge clk);
      if (done === 1'b1) dcount++;
    end
    checkOutput("abort_no_done", dcount, 0);
    applyStimulus("after_abort", 16'h1111, 8'hAA, 1'b0, 1'b0);

    // Randomized runs against the reference rule
    for (int r = 0; r < 3; r++) begin
      m = 16'($urandom);
      applyStimulus($sformatf("random%0d", r), m, modelResponse(m), 1'b0, 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
